mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/types_pkg.sv | 21 ++
 rtl/arb_starve_counter.sv | 32 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the memory-side blocks: byte-lane format and arbiter response-owner states.
package types_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } byte_format;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IF_RD = 2'd1,
        ARB_DM_RD = 2'd2
    } arb_state_t;

    // A limit of zero still needs a one-bit counter to hold the constant zero.
    function automatic int starveCntWidth(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating up-counter tracking consecutive data grants taken while fetch was waiting.
module arb_starve_counter
    import types_pkg::*;
#(
    parameter int LIMIT = 3,
    parameter int WIDTH = starveCntWidth(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic atLimit
);

    localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    assign atLimit = (count == LIMIT_C);

    // Clear wins over increment so a fetch grant always restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !atLimit) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / data) onto a single-port memory with 1-cycle read latency.
//   state     | meaning
//   ARB_IDLE  | no read response due this cycle
//   ARB_IF_RD | mem_rdata this cycle belongs to fetch
//   ARB_DM_RD | mem_rdata this cycle belongs to data port
module mem_arbiter
    import types_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  byte_format            dm_bsel,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output byte_format            mem_bsel,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t state;
    arb_state_t nextState;
    logic       ifGnt;
    logic       dmGnt;
    logic       starveAtLimit;
    logic       starveInc;
    logic       starveClr;

    assign starveInc = dmGnt && if_req;
    assign starveClr = ifGnt || !if_req;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) starveCounter (
        .clk     (clk),
        .rst     (rst),
        .inc     (starveInc),
        .clr     (starveClr),
        .atLimit (starveAtLimit)
    );

    // Grants are masked during reset so nothing reaches memory while rst is high.
    always_comb begin
        ifGnt = 1'b0;
        dmGnt = 1'b0;
        if (!rst) begin
            if (dm_req && if_req) begin
                if (starveAtLimit) begin
                    ifGnt = 1'b1;
                end else begin
                    dmGnt = 1'b1;
                end
            end else if (dm_req) begin
                dmGnt = 1'b1;
            end else if (if_req) begin
                ifGnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = ARB_IDLE;
        if_gnt    = ifGnt;
        dm_gnt    = dmGnt;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_bsel  = WORD;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;

        if (dmGnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_bsel  = dm_bsel;
            nextState = dm_we ? ARB_IDLE : ARB_DM_RD;
        end else if (ifGnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            nextState = ARB_IF_RD;
        end

        // Response routing depends only on the registered owner, so it overlaps the next grant.
        case (state)
            ARB_IF_RD: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            ARB_DM_RD: begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant priority, starvation, routing, writes and reset behaviour.
module tb_mem_arbiter;
    import types_pkg::*;

    localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    byte_format  dm_bsel = WORD;
    logic [31:0] mem_rdata = '0;

    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    byte_format  mem_bsel;

    logic        z_if_gnt, z_if_rvalid, z_dm_gnt, z_dm_rvalid, z_mem_en, z_mem_we;
    logic [31:0] z_if_rdata, z_dm_rdata, z_mem_addr, z_mem_wdata;
    byte_format  z_mem_bsel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: a read returns its address xor a key one cycle later; otherwise junk.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr ^ RD_KEY;
        else                   mem_rdata <= 32'hBAD0_0000;
    end

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_bsel(dm_bsel),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_bsel(mem_bsel), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.STARVE_LIMIT(0)) dutZero (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(z_if_gnt), .if_rvalid(z_if_rvalid), .if_rdata(z_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_bsel(dm_bsel),
        .dm_gnt(z_dm_gnt), .dm_rvalid(z_dm_rvalid), .dm_rdata(z_dm_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_bsel(z_mem_bsel), .mem_rdata(mem_rdata)
    );

    task automatic idleInputs();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_bsel = WORD;
    endtask

    task automatic test_reset();
        if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h44; dm_addr = 32'h88;
        @(negedge clk); #1;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got %b want 0", if_gnt); end
        checks++; if (dm_gnt !== 1'b0) begin errors++; $display("FAIL rst_dm_gnt got %b want 0", dm_gnt); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_en_we got %b%b want 00", mem_en, mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        checks++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b%b want 00", if_rvalid, dm_rvalid); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h %h want 0 0", if_rdata, dm_rdata); end
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin errors++; $display("FAIL rst_release_rvalid got %b%b want 00", if_rvalid, dm_rvalid); end
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        checks++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin errors++; $display("FAIL ifrd_gnt got if=%b dm=%b want 1 0", if_gnt, dm_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ifrd_mem_en_we got %b%b want 10", mem_en, mem_we); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL ifrd_mem_addr got %h want 00000010", mem_addr); end
        checks++; if (mem_bsel !== WORD) begin errors++; $display("FAIL ifrd_mem_bsel got %0d want %0d", mem_bsel, WORD); end
        checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL ifrd_early_rvalid got %b want 0", if_rvalid); end
        @(negedge clk);
        idleInputs();
        #1;
        checks++; if (if_rvalid !== 1'b1) begin errors++; $display("FAIL ifrd_rvalid got %b want 1", if_rvalid); end
        checks++; if (if_rdata !== 32'hA5A5_0010) begin errors++; $display("FAIL ifrd_rdata got %h want a5a50010", if_rdata); end
        checks++; if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL ifrd_dm_quiet got %b %h want 0 0", dm_rvalid, dm_rdata); end
        checks++; if (mem_en !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL ifrd_mem_idle got en=%b a=%h d=%h want 0 0 0", mem_en, mem_addr, mem_wdata); end
        @(negedge clk); #1;
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL ifrd_rvalid_drop got %b %h want 0 0", if_rvalid, if_rdata); end
    endtask

    // Expected grant sequence with both requesting and a limit of 3: dm,dm,dm,if repeating.
    task automatic test_starvation();
        logic expIf;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h4; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            expIf = ((i % 4) == 3);
            checks++; if (if_gnt !== expIf || dm_gnt !== !expIf) begin errors++; $display("FAIL starve_cycle%0d got if=%b dm=%b want if=%b", i, if_gnt, dm_gnt, expIf); end
            checks++; if (mem_addr !== (expIf ? 32'h4 : 32'h30)) begin errors++; $display("FAIL starve_addr%0d got %h want %h", i, mem_addr, expIf ? 32'h4 : 32'h30); end
        end
        // Two dm grants, then fetch drops for one cycle, which clears the count.
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL starve_pre_clear got dm=%b want 1", dm_gnt); end
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            expIf = (i == 3);
            checks++; if (if_gnt !== expIf || dm_gnt !== !expIf) begin errors++; $display("FAIL starve_after_clear%0d got if=%b dm=%b want if=%b", i, if_gnt, dm_gnt, expIf); end
        end
        @(negedge clk);
        idleInputs();
        @(negedge clk);
    endtask

    task automatic test_write();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_bsel = WORD;
        #1;
        checks++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got dm=%b if=%b want 1 0", dm_gnt, if_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_en_we got %b%b want 11", mem_en, mem_we); end
        checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_mem_bus got a=%h d=%h want 00000100 deadbeef", mem_addr, mem_wdata); end
        checks++; if (mem_bsel !== WORD) begin errors++; $display("FAIL wr_bsel_word got %0d want %0d", mem_bsel, WORD); end
        @(negedge clk);
        dm_addr = 32'h102; dm_wdata = 32'h0000_5A5A; dm_bsel = HALF;
        #1;
        checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got dm=%b if=%b want 0 0", dm_rvalid, if_rvalid); end
        checks++; if (mem_bsel !== HALF || mem_addr !== 32'h102) begin errors++; $display("FAIL wr_bsel_half got b=%0d a=%h want %0d 00000102", mem_bsel, mem_addr, HALF); end
        @(negedge clk);
        idleInputs();
        #1;
        checks++; if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL wr2_no_rvalid got %b %h want 0 0", dm_rvalid, dm_rdata); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        #1;
        checks++; if (dm_gnt !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL b2b_dm_gnt got g=%b a=%h want 1 00000020", dm_gnt, mem_addr); end
        @(negedge clk);
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h0;
        #1;
        checks++; if (if_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL b2b_if_gnt got g=%b en=%b a=%h want 1 1 0", if_gnt, mem_en, mem_addr); end
        checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hA5A5_0020) begin errors++; $display("FAIL b2b_dm_resp got %b %h want 1 a5a50020", dm_rvalid, dm_rdata); end
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL b2b_if_quiet1 got %b %h want 0 0", if_rvalid, if_rdata); end
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h20;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL b2b_if_resp got %b %h want 1 a5a50000", if_rvalid, if_rdata); end
        checks++; if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL b2b_dm_quiet got %b %h want 0 0", dm_rvalid, dm_rdata); end
        @(negedge clk);
        idleInputs();
        #1;
        checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hA5A5_0020 || if_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_dm_resp2 got %b %h if=%b want 1 a5a50020 0", dm_rvalid, dm_rdata, if_rvalid); end
        @(negedge clk); #1;
        checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_settle got %b %b want 0 0", dm_rvalid, if_rvalid); end
    endtask

    // A request that vanishes before the clock edge must leave no response behind.
    task automatic test_drop_req();
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 32'h40;
        #1;
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL drop_gnt_seen got %b want 1", dm_gnt); end
        #1;
        dm_req = 1'b0;
        @(negedge clk); #1;
        checks++; if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL drop_no_rvalid got %b %h want 0 0", dm_rvalid, dm_rdata); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 32'h20;
        #1;
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b want 1", dm_gnt); end
        @(negedge clk);
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h8;
        rst = 1'b1;
        #1;
        checks++; if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL rmid_dm_rvalid got %b %h want 0 0", dm_rvalid, dm_rdata); end
        checks++; if (if_gnt !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_outputs got g=%b en=%b a=%h want 0 0 0", if_gnt, mem_en, mem_addr); end
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        #1;
        checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_release got dm=%b if=%b want 0 0", dm_rvalid, if_rvalid); end
        @(negedge clk); #1;
        checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_release2 got dm=%b if=%b want 0 0", dm_rvalid, if_rvalid); end
    endtask

    task automatic test_limit_zero();
        @(negedge clk);
        if_req = 1'b1; dm_req = 1'b1; if_addr = 32'hC; dm_addr = 32'h50;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (z_if_gnt !== 1'b1 || z_dm_gnt !== 1'b0) begin errors++; $display("FAIL lim0_cycle%0d got if=%b dm=%b want 1 0", i, z_if_gnt, z_dm_gnt); end
        end
        @(negedge clk);
        idleInputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_starvation();
        test_write();
        test_back_to_back();
        test_drop_req();
        test_reset_mid();
        test_limit_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
